// File: rtl/ppu_pkg.sv
// ppu_pkg: shared PPU definitions for the OAM scanner and the sprite fetcher.
// Contents:
//   OAM_BASE, OAM_ENTRIES, MAX_SPRITES  - OAM layout and sprite-buffer depth
//   ScanState                           - mode-2 scan FSM states
//   SPRITE_ENTRY_W, SPR_*_LSB/_W        - sprite-buffer slot packing
//   pack_sprite()                       - builds one slot {X, sprite_num, row}
package ppu_pkg;

  localparam logic [15:0] OAM_BASE    = 16'hFE00;
  localparam int          OAM_ENTRIES = 40;
  localparam int          MAX_SPRITES = 10;

  // Slot layout, LSB first: row[3:0], sprite_num[9:4], X[17:10].
  localparam int SPRITE_ENTRY_W = 18;
  localparam int SPR_ROW_LSB    = 0;
  localparam int SPR_ROW_W      = 4;
  localparam int SPR_NUM_LSB    = 4;
  localparam int SPR_NUM_W      = 6;
  localparam int SPR_X_LSB      = 10;
  localparam int SPR_X_W        = 8;

  typedef enum logic [2:0] {
    Idle   = 3'd0,
    ReadY  = 3'd1,
    ReadX  = 3'd2,
    Commit = 3'd3,
    Done   = 3'd4
  } ScanState;

  function automatic logic [SPRITE_ENTRY_W-1:0] pack_sprite(
    input logic [SPR_X_W-1:0]   x,
    input logic [SPR_NUM_W-1:0] num,
    input logic [SPR_ROW_W-1:0] row
  );
    logic [SPRITE_ENTRY_W-1:0] e;
    e = '0;
    e[SPR_X_LSB   +: SPR_X_W]   = x;
    e[SPR_NUM_LSB +: SPR_NUM_W] = num;
    e[SPR_ROW_LSB +: SPR_ROW_W] = row;
    return e;
  endfunction

endpackage

// File: rtl/oam_y_match.sv
// oam_y_match: combinational vertical-overlap test of one sprite against a line.
// Ports:
//   y     in  8  sprite Y byte from OAM (screen line + 16)
//   ly    in  8  current line
//   tall  in  1  0: 8-row sprites, 1: 16-row sprites
//   hit   out 1  sprite covers this line
//   row   out 4  row of the sprite that falls on this line
module oam_y_match
  import ppu_pkg::*;
(
  input  logic [7:0]           y,
  input  logic [7:0]           ly,
  input  logic                 tall,
  output logic                 hit,
  output logic [SPR_ROW_W-1:0] row
);

  // 9-bit arithmetic so that LY+16 never wraps for lines near 255.
  logic [8:0] ly16;
  logic [8:0] diff;
  logic [8:0] height;

  assign ly16   = {1'b0, ly} + 9'd16;
  assign diff   = ly16 - {1'b0, y};
  assign height = tall ? 9'd16 : 9'd8;
  assign hit    = (ly16 >= {1'b0, y}) && (diff < height);
  assign row    = diff[SPR_ROW_W-1:0];

endmodule

// File: rtl/oam_scanner.sv
// oam_scanner: PPU mode-2 OAM scan. Walks all OAM entries for the current line
// and packs up to MAX_SPRITES overlapping sprites into the sprite buffer.
// Optional build macro: OAM_SCAN_OVF_EN adds the sticky overflow_out port.
// Ports:
//   clk_in, rst_n_in        clock, async active-low reset
//   tclk_in                 T-cycle enable; all FSM moves happen on it
//   start_in                begin a scan (sampled with tclk_in)
//   LY_in                   current line, sampled at each Y evaluation
//   tall_sprite_mode_in     0: 8-row, 1: 16-row sprites
//   oam_addr_out/oam_req_out  OAM byte read request (req is one clk_in wide)
//   oam_data_in/oam_valid_in  OAM read response, any clk_in cycle
//   consume_valid_in/consume_idx_in  fetcher done with slot -> clear its X
//   sprite_buffer_out       MAX_SPRITES packed slots, slot 0 in the LSBs
//   sprite_count_out        hits stored this line
//   scanning_out, done_out  scan in progress / finished (done held until start)
//   overflow_out            (OAM_SCAN_OVF_EN only) a hit was dropped
//   state_out               current FSM state, for observation
// OAM handshake: a request is a single-cycle oam_req_out pulse with
// oam_addr_out stable alongside it; the responder answers with a single-cycle
// oam_valid_in any time before the next tclk_in. A missing answer reads 8'hFF.
module oam_scanner
  import ppu_pkg::*;
(
  input  logic                                       clk_in,
  input  logic                                       rst_n_in,
  input  logic                                       tclk_in,
  input  logic                                       start_in,
  input  logic [7:0]                                 LY_in,
  input  logic                                       tall_sprite_mode_in,
  output logic [15:0]                                oam_addr_out,
  output logic                                       oam_req_out,
  input  logic [7:0]                                 oam_data_in,
  input  logic                                       oam_valid_in,
  input  logic                                       consume_valid_in,
  input  logic [3:0]                                 consume_idx_in,
  output logic [MAX_SPRITES-1:0][SPRITE_ENTRY_W-1:0] sprite_buffer_out,
  output logic [3:0]                                 sprite_count_out,
  output logic                                       scanning_out,
  output logic                                       done_out,
`ifdef OAM_SCAN_OVF_EN
  output logic                                       overflow_out,
`endif
  output ScanState                                   state_out
);

  localparam logic [5:0] LAST_ENTRY = 6'(OAM_ENTRIES - 1);
  localparam logic [3:0] SLOT_LIMIT = 4'(MAX_SPRITES);

  ScanState state_q;
  ScanState state_d;

  logic [5:0]  n_q;
  logic [3:0]  count_q;
  logic [MAX_SPRITES-1:0][SPRITE_ENTRY_W-1:0] slots_q;

  logic [7:0]  y_byte_q;
  logic [7:0]  x_byte_q;
  logic [7:0]  y_eff;
  logic [7:0]  x_eff;

  // Result of the Y evaluation of entry n, committed one tclk later once
  // its X byte has arrived.
  logic                 pend_valid_q;
  logic                 pend_hit_q;
  logic [SPR_ROW_W-1:0] pend_row_q;
  logic [SPR_NUM_W-1:0] pend_num_q;

  logic        do_clear;
  logic        do_req_y;
  logic        do_req_x;
  logic        do_commit;
  logic        y_hit;
  logic [SPR_ROW_W-1:0] y_row;
  logic        commit_store;
  logic        consume_ok;
  logic [15:0] entry_addr;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= Idle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    do_clear  = 1'b0;
    do_req_y  = 1'b0;
    do_req_x  = 1'b0;
    do_commit = 1'b0;
    if (tclk_in) begin
      if (start_in) begin
        do_clear = 1'b1;
        state_d  = ReadY;
      end else begin
        case (state_q)
          Idle: state_d = Idle;
          ReadY: begin
            do_req_y  = 1'b1;
            do_commit = pend_valid_q;
            state_d   = ReadX;
          end
          ReadX: begin
            do_req_x = 1'b1;
            state_d  = (n_q == LAST_ENTRY) ? Commit : ReadY;
          end
          Commit: begin
            do_commit = pend_valid_q;
            state_d   = Done;
          end
          Done:    state_d = Done;
          default: state_d = Idle;
        endcase
      end
    end
  end

  // ------------------------------------------------------ byte capture
  // The Y byte is in flight while the FSM sits in ReadX, the X byte while it
  // sits in ReadY/Commit. A byte landing on the same cycle as the tclk that
  // consumes it is forwarded straight through.
  assign y_eff = (oam_valid_in && (state_q == ReadX)) ? oam_data_in : y_byte_q;
  assign x_eff = (oam_valid_in && ((state_q == ReadY) || (state_q == Commit)))
                 ? oam_data_in : x_byte_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      y_byte_q <= 8'h00;
      x_byte_q <= 8'h00;
    end else begin
      if (do_clear || do_req_y) begin
        y_byte_q <= 8'hFF;
      end else if (oam_valid_in && (state_q == ReadX)) begin
        y_byte_q <= oam_data_in;
      end
      if (do_clear || do_req_x) begin
        x_byte_q <= 8'hFF;
      end else if (oam_valid_in && ((state_q == ReadY) || (state_q == Commit))) begin
        x_byte_q <= oam_data_in;
      end
    end
  end

  // --------------------------------------------------------- Y compare
  oam_y_match u_y_match (
    .y    (y_eff),
    .ly   (LY_in),
    .tall (tall_sprite_mode_in),
    .hit  (y_hit),
    .row  (y_row)
  );

  // ------------------------------------------------ entry index, pending
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      n_q          <= 6'd0;
      pend_valid_q <= 1'b0;
      pend_hit_q   <= 1'b0;
      pend_row_q   <= '0;
      pend_num_q   <= '0;
    end else if (do_clear) begin
      n_q          <= 6'd0;
      pend_valid_q <= 1'b0;
      pend_hit_q   <= 1'b0;
      pend_row_q   <= '0;
      pend_num_q   <= '0;
    end else begin
      if (do_commit) begin
        pend_valid_q <= 1'b0;
      end
      if (do_req_x) begin
        pend_valid_q <= 1'b1;
        pend_hit_q   <= y_hit;
        pend_row_q   <= y_row;
        pend_num_q   <= n_q;
        if (n_q != LAST_ENTRY) begin
          n_q <= n_q + 6'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------- OAM reads
  assign entry_addr = OAM_BASE + {8'h00, n_q, 2'b00};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      oam_req_out  <= 1'b0;
      oam_addr_out <= 16'h0000;
    end else begin
      oam_req_out <= do_req_y | do_req_x;
      if (do_req_y) begin
        oam_addr_out <= entry_addr;
      end else if (do_req_x) begin
        oam_addr_out <= entry_addr + 16'd1;
      end
    end
  end

  // ------------------------------------------------------ sprite buffer
  assign commit_store = do_commit && pend_hit_q && (count_q < SLOT_LIMIT);
  assign consume_ok   = consume_valid_in && (consume_idx_in < SLOT_LIMIT);

  // Consume is written before the commit so that a commit to the same slot
  // on the same cycle overrides it; start clears everything and wins over both.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      slots_q <= '0;
      count_q <= 4'd0;
    end else if (do_clear) begin
      slots_q <= '0;
      count_q <= 4'd0;
    end else begin
      if (consume_ok) begin
        slots_q[consume_idx_in][SPR_X_LSB +: SPR_X_W] <= '0;
      end
      if (commit_store) begin
        slots_q[count_q] <= pack_sprite(x_eff, pend_num_q, pend_row_q);
        count_q          <= count_q + 4'd1;
      end
    end
  end

`ifdef OAM_SCAN_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ovf_q <= 1'b0;
    end else if (do_clear) begin
      ovf_q <= 1'b0;
    end else if (do_commit && pend_hit_q && (count_q >= SLOT_LIMIT)) begin
      ovf_q <= 1'b1;
    end
  end

  assign overflow_out = ovf_q;
`endif

  // ------------------------------------------------------------ outputs
  assign sprite_buffer_out = slots_q;
  assign sprite_count_out  = count_q;
  assign scanning_out      = (state_q == ReadY) || (state_q == ReadX) || (state_q == Commit);
  assign done_out          = (state_q == Done);
  assign state_out         = state_q;

endmodule

// File: tb/tb_oam_scanner.sv
module tb_oam_scanner;
  import ppu_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        tclk_in;
  logic        start_in;
  logic [7:0]  LY_in;
  logic        tall_sprite_mode_in;
  logic [15:0] oam_addr_out;
  logic        oam_req_out;
  logic [7:0]  oam_data_in;
  logic        oam_valid_in;
  logic        consume_valid_in;
  logic [3:0]  consume_idx_in;
  logic [MAX_SPRITES-1:0][SPRITE_ENTRY_W-1:0] sprite_buffer_out;
  logic [3:0]  sprite_count_out;
  logic        scanning_out;
  logic        done_out;
`ifdef OAM_SCAN_OVF_EN
  logic        overflow_out;
`endif
  ScanState    state_out;

  oam_scanner dut (
    .clk_in              (clk_in),
    .rst_n_in            (rst_n_in),
    .tclk_in             (tclk_in),
    .start_in            (start_in),
    .LY_in               (LY_in),
    .tall_sprite_mode_in (tall_sprite_mode_in),
    .oam_addr_out        (oam_addr_out),
    .oam_req_out         (oam_req_out),
    .oam_data_in         (oam_data_in),
    .oam_valid_in        (oam_valid_in),
    .consume_valid_in    (consume_valid_in),
    .consume_idx_in      (consume_idx_in),
    .sprite_buffer_out   (sprite_buffer_out),
    .sprite_count_out    (sprite_count_out),
    .scanning_out        (scanning_out),
    .done_out            (done_out),
`ifdef OAM_SCAN_OVF_EN
    .overflow_out        (overflow_out),
`endif
    .state_out           (state_out)
  );

  // ---------------------------------------------------- clock / reset
  always #5 clk_in = ~clk_in;

  // ------------------------------------------------------------ state
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [17:0] exp_q[$];
  logic [7:0] oam_mem [0:159];
  int         withhold_idx = -1;
  bit         start_req = 1'b0;
  int         tclk_num = 0;

  task automatic check(input string tag, input logic [179:0] got, input logic [179:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // tclk_in: one clk_in wide every fourth cycle; start_in rides on it.
  int unsigned phase = 0;
  initial begin
    tclk_in  = 1'b0;
    start_in = 1'b0;
    forever begin
      @(negedge clk_in);
      phase = (phase + 1) % 4;
      if (phase == 0) begin
        tclk_in   = 1'b1;
        start_in  = start_req;
        start_req = 1'b0;
      end else begin
        tclk_in  = 1'b0;
        start_in = 1'b0;
      end
    end
  end

  // tclk edge number relative to the last accepted start (start edge = 0).
  always @(posedge clk_in) begin
    if (tclk_in) begin
      if (start_in) tclk_num = 0;
      else          tclk_num = tclk_num + 1;
    end
  end

  // OAM responder: answers each request one cycle later unless withheld.
  int resp_idx;
  initial begin
    oam_valid_in = 1'b0;
    oam_data_in  = 8'h00;
    forever begin
      @(negedge clk_in);
      oam_valid_in = 1'b0;
      if (oam_req_out && rst_n_in) begin
        resp_idx = int'(oam_addr_out) - int'(OAM_BASE);
        if (resp_idx >= 0 && resp_idx < 160 && resp_idx != withhold_idx) begin
          oam_valid_in = 1'b1;
          oam_data_in  = oam_mem[resp_idx];
        end
      end
    end
  end

  // ---------------------------------------------------------- drivers
  task automatic clear_mem();
    for (int i = 0; i < 160; i++) oam_mem[i] = 8'h00;
  endtask

  task automatic set_entry(input int n, input logic [7:0] y, input logic [7:0] x);
    oam_mem[4*n]     = y;
    oam_mem[4*n + 1] = x;
  endtask

  task automatic start_scan(input string tag);
    int guard = 0;
    start_req = 1'b1;
    while (start_req && guard < 20) begin
      @(posedge clk_in);
      guard++;
    end
    check({tag, " start accepted"}, start_req, 1'b0);
    @(negedge clk_in);
  endtask

  task automatic wait_done(input string tag);
    int cyc = 0;
    while (!done_out && cyc < 2000) begin
      @(negedge clk_in);
      cyc++;
    end
    check({tag, " done within bound"}, (cyc < 2000), 1'b1);
    check({tag, " done latency"}, tclk_num, 81);
    check({tag, " scanning low"}, scanning_out, 1'b0);
  endtask

  task automatic wait_tclk(input int num);
    int cyc = 0;
    while (tclk_num != num && cyc < 2000) begin
      @(negedge clk_in);
      cyc++;
    end
    check("reached tclk", tclk_num, num);
  endtask

  task automatic consume(input logic [3:0] idx);
    consume_valid_in = 1'b1;
    consume_idx_in   = idx;
    @(negedge clk_in);
    consume_valid_in = 1'b0;
    consume_idx_in   = 4'd0;
    @(negedge clk_in);
  endtask

  task automatic push_zeros_to(input int total);
    while (exp_q.size() < total) exp_q.push_back(18'h0);
  endtask

  // Scoreboard: pops the ten expected slots in order.
  task automatic check_slots(input string tag);
    logic [17:0] e;
    for (int k = 0; k < MAX_SPRITES; k++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h0;
      check($sformatf("%s slot%0d", tag, k), sprite_buffer_out[k], e);
    end
    exp_q.delete();
  endtask

  task automatic expect_t2(input string tag);
    for (int k = 0; k < 10; k++) exp_q.push_back(18'(32'hC801 + 32'h10 * k));
    check({tag, " count"}, sprite_count_out, 4'd10);
    check_slots(tag);
`ifdef OAM_SCAN_OVF_EN
    check({tag, " overflow"}, overflow_out, 1'b1);
`endif
  endtask

  // --------------------------------------------------------- sequence
  initial begin
    rst_n_in            = 1'b0;
    LY_in               = 8'd0;
    tall_sprite_mode_in = 1'b0;
    consume_valid_in    = 1'b0;
    consume_idx_in      = 4'd0;
    clear_mem();
    repeat (3) @(negedge clk_in);

    check("rst buffer", sprite_buffer_out, '0);
    check("rst count", sprite_count_out, 4'd0);
    check("rst req", oam_req_out, 1'b0);
    check("rst addr", oam_addr_out, 16'h0);
    check("rst scanning", scanning_out, 1'b0);
    check("rst done", done_out, 1'b0);
    check("rst state", state_out, Idle);
    rst_n_in = 1'b1;
    repeat (2) @(negedge clk_in);

    // T1: single 8-row sprite on line 0.
    set_entry(0, 8'd16, 8'd8);
    LY_in = 8'd0;
    start_scan("t1");
    check("t1 scanning", scanning_out, 1'b1);
    check("t1 done low", done_out, 1'b0);
    wait_done("t1");
    check("t1 count", sprite_count_out, 4'd1);
    exp_q.push_back(18'h02000);
    check_slots("t1");
`ifdef OAM_SCAN_OVF_EN
    check("t1 overflow", overflow_out, 1'b0);
`endif

    // T2: twelve hits, only ten fit.
    clear_mem();
    for (int i = 0; i < 12; i++) set_entry(i, 8'd20, 8'd50);
    LY_in = 8'd5;
    start_scan("t2");
    wait_done("t2");
    expect_t2("t2");

    // T3: row 10 is only inside a tall sprite.
    clear_mem();
    set_entry(3, 8'd16, 8'h20);
    LY_in = 8'd10;
    tall_sprite_mode_in = 1'b1;
    start_scan("t3a");
    wait_done("t3a");
    check("t3a count", sprite_count_out, 4'd1);
    exp_q.push_back(18'h0803A);
    check_slots("t3a");
    tall_sprite_mode_in = 1'b0;
    start_scan("t3b");
    wait_done("t3b");
    check("t3b count", sprite_count_out, 4'd0);
    check_slots("t3b");

    // T4: entry 7's Y byte never arrives -> reads as FF, no hit.
    clear_mem();
    set_entry(6, 8'd16, 8'h11);
    set_entry(7, 8'd16, 8'h22);
    set_entry(8, 8'd16, 8'h33);
    LY_in = 8'd0;
    withhold_idx = 28;
    start_scan("t4");
    wait_done("t4");
    withhold_idx = -1;
    check("t4 count", sprite_count_out, 4'd2);
    exp_q.push_back(18'h04460);
    exp_q.push_back(18'h0CC80);
    check_slots("t4");

    // T5: four hits, then consume slot 3 and an out-of-range slot.
    clear_mem();
    set_entry(0,  8'd16, 8'h01);
    set_entry(5,  8'd16, 8'h02);
    set_entry(10, 8'd16, 8'h03);
    set_entry(20, 8'd14, 8'h04);
    start_scan("t5");
    wait_done("t5");
    check("t5 count", sprite_count_out, 4'd4);
    exp_q.push_back(18'h00400);
    exp_q.push_back(18'h00850);
    exp_q.push_back(18'h00CA0);
    exp_q.push_back(18'h01142);
    check_slots("t5");
    consume(4'd3);
    check("t5 count after consume", sprite_count_out, 4'd4);
    exp_q.push_back(18'h00400);
    exp_q.push_back(18'h00850);
    exp_q.push_back(18'h00CA0);
    exp_q.push_back(18'h00142);
    push_zeros_to(10);
    check_slots("t5 consume3");
    consume(4'd12);
    exp_q.push_back(18'h00400);
    exp_q.push_back(18'h00850);
    exp_q.push_back(18'h00CA0);
    exp_q.push_back(18'h00142);
    check_slots("t5 consume12");

    // T6: reset in the middle of a scan, then a clean rescan.
    clear_mem();
    for (int i = 0; i < 12; i++) set_entry(i, 8'd20, 8'd50);
    LY_in = 8'd5;
    start_scan("t6");
    wait_tclk(40);
    check("t6 busy before reset", sprite_count_out, 4'd10);
    rst_n_in = 1'b0;
    #1;
    check("t6 rst buffer", sprite_buffer_out, '0);
    check("t6 rst count", sprite_count_out, 4'd0);
    check("t6 rst req", oam_req_out, 1'b0);
    check("t6 rst addr", oam_addr_out, 16'h0);
    check("t6 rst scanning", scanning_out, 1'b0);
    check("t6 rst done", done_out, 1'b0);
    check("t6 rst state", state_out, Idle);
`ifdef OAM_SCAN_OVF_EN
    check("t6 rst overflow", overflow_out, 1'b0);
`endif
    @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (2) @(negedge clk_in);
    start_scan("t6 rescan");
    wait_done("t6 rescan");
    expect_t2("t6 rescan");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/oam_scanner.md
Name: oam_scanner

Overview:
- PPU mode-2 stage that sits directly upstream of the sprite fetcher.
- Walks all 40 OAM entries for the current line (LY) and selects up to 10 sprites that vertically overlap it.
- Packs each selected sprite into the 18-bit sprite-buffer format the fetcher consumes: {X[7:0], sprite_num[5:0], row[3:0]}.
- Clears an entry's X once the fetcher has rendered it, so that sprite is not matched again.

Parameters:
- OAM_ENTRIES, 40, number of OAM entries scanned per line.
- MAX_SPRITES, 10, number of sprite-buffer slots.
- OAM_BASE, 16'hFE00, byte address of OAM entry 0.

Ports:
- clk_in  in  1  system clock.
- rst_n_in  in  1  reset, asynchronous, active-low.
- tclk_in  in  1  T-cycle enable pulse, one clk_in wide.
- start_in  in  1  begin a scan; sampled only when tclk_in=1.
- LY_in  in  8  current line.
- tall_sprite_mode_in  in  1  0: 8-row sprites, 1: 16-row sprites.
- oam_addr_out  out  16  OAM byte address.
- oam_req_out  out  1  read request strobe.
- oam_data_in  in  8  OAM read data.
- oam_valid_in  in  1  oam_data_in is valid; may arrive on any clk_in cycle.
- consume_valid_in  in  1  fetcher has finished with a slot.
- consume_idx_in  in  4  index of that slot.
- sprite_buffer_out  out  18 x MAX_SPRITES  packed sprite slots.
- sprite_count_out  out  4  hits stored this line, 0..10.
- scanning_out  out  1  scan in progress.
- done_out  out  1  scan complete; held until the next start.

Behaviour:
- Reset (async, rst_n_in=0):
  - State Idle.
  - All slots 18'h0; sprite_count_out 0.
  - oam_req_out 0, oam_addr_out 16'h0.
  - scanning_out 0, done_out 0.
  - Captured bytes and the pending commit are cleared. Reset mid-scan abandons the scan.
- States: Idle, ReadY, ReadX, Commit, Done. Transitions happen only on clk_in edges where tclk_in=1.
- start_in=1 on a tclk_in edge, in any state:
  - Clear all slots to 0, set count 0 and entry index n=0.
  - Clear the captured Y/X bytes and any pending commit.
  - done_out 0, next state ReadY.
- ReadY (on tclk_in):
  - oam_addr_out=OAM_BASE+4n, oam_req_out=1 for that single clk_in cycle.
  - Commit entry n-1 if a commit is pending.
  - Next state ReadX.
- ReadX (on tclk_in):
  - Evaluate the captured Y into y_hit and row.
  - Request OAM_BASE+4n+1.
  - If n=39, next state is Commit; otherwise n++ and next state is ReadY.
- Commit (one tclk): commit entry 39, then go to Done.
- Done: done_out=1, scanning_out=0; stay here until start_in.
- Latency: start at tclk t0; done_out rises on the t81 tclk edge.
- Capture: Y and X bytes are latched whenever oam_valid_in=1 during their phase. A byte not received before the next tclk_in reads as 8'hFF.
- Y match, with 9-bit arithmetic:
  - ly16 = LY_in + 16.
  - Hit iff ly16 >= Y and (ly16 - Y) < (tall ? 16 : 8).
  - row = (ly16 - Y)[3:0].
- Commit of entry n:
  - If y_hit and count < MAX_SPRITES: slot[count] = {X, n[5:0], row}, then count++.
  - If count == MAX_SPRITES, the hit is dropped.
  - Sprites with X=0 still take a slot; the fetcher ignores them.
- Slot order follows OAM order.
- Consume:
  - consume_valid_in on any clk_in cycle (no tclk_in needed) with consume_idx_in < MAX_SPRITES clears slot[idx][17:10] to 0.
  - idx >= MAX_SPRITES is ignored.
  - A consume does not change count.
- Simultaneous events:
  - start_in beats consume.
  - A commit and a consume on the same cycle hitting the same slot: the commit wins.
- LY_in and tall_sprite_mode_in are sampled at evaluation time and are not latched at start.

Optional Feature:
- OAM_SCAN_OVF_EN defined:
  - Adds output port overflow_out (1 bit).
  - Sticky; set when a Y hit is dropped because count == MAX_SPRITES.
  - Cleared on start_in and on reset.
- OAM_SCAN_OVF_EN undefined: the port and its logic are absent; extra hits are silently dropped.

Decomposition:
- Shared package ppu_pkg holds:
  - OAM_BASE, OAM_ENTRIES, MAX_SPRITES constants.
  - typedef enum ScanState {Idle, ReadY, ReadX, Commit, Done}.
  - SPRITE_ENTRY_W=18 plus field offsets, so this block and the fetcher agree on the packing.
- One combinational sub-module: oam_y_match (inputs Y, LY, tall; outputs hit, row). It keeps the 9-bit compare isolated and testable.

Test Plan:
- LY=0, entry0 Y=16 X=8, all other entries Y=0 -> slot0=18'h02000, count=1, other slots 0, done_out on t81.
- LY=5, entries 0..11 Y=20 X=50 -> slots 0..9 hold sprite nums 0..9 with row=1; count=10; overflow_out=1 when enabled.
- LY=10, entry 3 Y=16 -> tall=1: slot0={X,6'd3,4'd10}, count=1; tall=0: count=0.
- oam_valid_in withheld for entry 7's Y byte -> treated as 8'hFF, no hit, scan otherwise unaffected.
- After a scan with 4 hits, consume_idx_in=3 -> slot3[17:10]=0, other fields and slots unchanged; consume_idx_in=12 -> no change.
- rst_n_in pulled low at t40 -> all outputs return to reset values immediately; a new start_in yields a full correct scan.
